// File: rtl/sa_fifo_rwsp_8x129_ctrl.sv
// sa_fifo_rwsp_8x129_ctrl
// FIFO controller driving both ports of an external 8x129 flop RAM whose
// read port has two register stages: a read-address register (loaded by
// ram_re) and an output data register (loaded by ram_ore). The controller
// hides that two-stage read pipeline behind a plain valid/ready read side.
//
// Pipeline bookkeeping:
//   unissued : entries written but whose address has not yet entered ra_d
//   s1_vld   : RAM ra_d holds the address of the next entry to read
//   s2_vld   : RAM dout register holds the head entry (presented on rd_pd)
//   count    : unissued + s1_vld + s2_vld, freed only when the head pops
//
// Optional build macro SA_FIFO_RWSP_HWM_EN adds a registered high-watermark
// output fifo_hwm and its synchronous clear input hwm_clr. Without the macro
// neither port nor the watermark logic exists.

module sa_fifo_rwsp_8x129_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int WIDTH = 129
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             wr_pvld,
   output logic             wr_prdy,
   input  logic [WIDTH-1:0] wr_pd,
   output logic             rd_pvld,
   input  logic             rd_prdy,
   output logic [WIDTH-1:0] rd_pd,
   output logic [AW-1:0]    ram_wa,
   output logic             ram_we,
   output logic [WIDTH-1:0] ram_di,
   output logic [AW-1:0]    ram_ra,
   output logic             ram_re,
   output logic             ram_ore,
   input  logic [WIDTH-1:0] ram_dout
`ifdef SA_FIFO_RWSP_HWM_EN
   ,
   input  logic             hwm_clr,
   output logic [AW:0]      fifo_hwm
`endif
);

   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ZERO = '0;
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] iss_ptr_q, iss_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   unissued_q, unissued_d;
   logic          s1_vld_q, s1_vld_d;
   logic          s2_vld_q, s2_vld_d;
   logic          wr_prdy_q, wr_prdy_d;

   logic          wr_acc;
   logic          issue;
   logic          advance;
   logic          pop;

   // Handshake decode: write accept, address issue into ra_d, data advance
   // into the dout register, and consumer pop.
   always_comb begin
      wr_acc  = wr_pvld & wr_prdy_q;
      advance = s1_vld_q & (~s2_vld_q | rd_prdy);
      issue   = (unissued_q != CNT_ZERO) & (~s1_vld_q | advance);
      pop     = s2_vld_q & rd_prdy;
   end

   // Next-state computation for pointers, occupancy and stage valids.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      iss_ptr_d  = iss_ptr_q;
      count_d    = count_q;
      unissued_d = unissued_q;
      s1_vld_d   = s1_vld_q;
      s2_vld_d   = s2_vld_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (issue) begin
         iss_ptr_d = iss_ptr_q + PTR_ONE;
      end

      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case ({wr_acc, issue})
         2'b10:   unissued_d = unissued_q + CNT_ONE;
         2'b01:   unissued_d = unissued_q - CNT_ONE;
         default: unissued_d = unissued_q;
      endcase

      if (issue) begin
         s1_vld_d = 1'b1;
      end else if (advance) begin
         s1_vld_d = 1'b0;
      end

      if (advance) begin
         s2_vld_d = 1'b1;
      end else if (pop) begin
         s2_vld_d = 1'b0;
      end

      wr_prdy_d = (count_d < CNT_FULL);
   end

   // State registers; a reset discards every entry in flight.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_ptr_q   <= '0;
         iss_ptr_q  <= '0;
         count_q    <= '0;
         unissued_q <= '0;
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         wr_prdy_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         iss_ptr_q  <= iss_ptr_d;
         count_q    <= count_d;
         unissued_q <= unissued_d;
         s1_vld_q   <= s1_vld_d;
         s2_vld_q   <= s2_vld_d;
         wr_prdy_q  <= wr_prdy_d;
      end
   end

   assign wr_prdy = wr_prdy_q;
   assign ram_we  = wr_acc;
   assign ram_wa  = wr_ptr_q;
   assign ram_di  = wr_pd;
   assign ram_re  = issue;
   assign ram_ra  = iss_ptr_q;
   assign ram_ore = advance;
   assign rd_pvld = s2_vld_q;
   assign rd_pd   = ram_dout;

`ifdef SA_FIFO_RWSP_HWM_EN
   logic [AW:0] fifo_hwm_q, fifo_hwm_d;

   // Watermark tracks the largest occupancy seen; clear wins over update.
   always_comb begin
      fifo_hwm_d = fifo_hwm_q;
      if (hwm_clr) begin
         fifo_hwm_d = '0;
      end else if (count_d > fifo_hwm_q) begin
         fifo_hwm_d = count_d;
      end
   end

   // Watermark register.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         fifo_hwm_q <= '0;
      end else begin
         fifo_hwm_q <= fifo_hwm_d;
      end
   end

   assign fifo_hwm = fifo_hwm_q;
`endif

endmodule

// File: tb/tb_sa_fifo_rwsp_8x129_ctrl.sv
// Testbench for sa_fifo_rwsp_8x129_ctrl. Contains a behavioural model of the
// external two-stage-read flop RAM and a queue-based FIFO reference model.
// Build with SA_FIFO_RWSP_HWM_EN defined to also exercise the watermark.

module tb_sa_fifo_rwsp_8x129_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int WIDTH = 129;

   logic             clk = 1'b0;
   logic             reset_ = 1'b1;
   logic             wr_pvld;
   logic             wr_prdy;
   logic [WIDTH-1:0] wr_pd;
   logic             rd_pvld;
   logic             rd_prdy;
   logic [WIDTH-1:0] rd_pd;
   logic [AW-1:0]    ram_wa;
   logic             ram_we;
   logic [WIDTH-1:0] ram_di;
   logic [AW-1:0]    ram_ra;
   logic             ram_re;
   logic             ram_ore;
   logic [WIDTH-1:0] ram_dout;
`ifdef SA_FIFO_RWSP_HWM_EN
   logic             hwm_clr = 1'b0;
   logic [AW:0]      fifo_hwm;
   int               hwmModel = 0;
`endif

   // RAM model state
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    raD;
   logic [WIDTH-1:0] doutQ;

   // Reference model and bookkeeping
   logic [WIDTH-1:0] expQ [$];
   int               nCompared = 0;
   int               nMismatched = 0;
   bit               prdyArmed = 1'b0;
   int               wrIdx = 0;
   int               issIdx = 0;
   int               accCount = 0;
   int               popCount = 0;
   int               weCount = 0;
   bit               prevStall = 1'b0;
   logic [WIDTH-1:0] prevPd;

   // Per-cycle samples taken at the falling edge
   logic             sWe, sRe, sOre, sPvld, sWrPrdy, sAcc, sPop;
   logic [WIDTH-1:0] sPd;

   always #5 clk = ~clk;

   sa_fifo_rwsp_8x129_ctrl dut (
      .clk      (clk),
      .reset_   (reset_),
      .wr_pvld  (wr_pvld),
      .wr_prdy  (wr_prdy),
      .wr_pd    (wr_pd),
      .rd_pvld  (rd_pvld),
      .rd_prdy  (rd_prdy),
      .rd_pd    (rd_pd),
      .ram_wa   (ram_wa),
      .ram_we   (ram_we),
      .ram_di   (ram_di),
      .ram_ra   (ram_ra),
      .ram_re   (ram_re),
      .ram_ore  (ram_ore),
      .ram_dout (ram_dout)
`ifdef SA_FIFO_RWSP_HWM_EN
      ,
      .hwm_clr  (hwm_clr),
      .fifo_hwm (fifo_hwm)
`endif
   );

   // Flop RAM with a registered read address and a registered data output.
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) raD <= ram_ra;
      if (ram_ore) doutQ <= mem[raD];
   end
   assign ram_dout = doutQ;

   function automatic logic [WIDTH-1:0] randWord();
      return {1'b1, $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rp);
      wr_pvld = wv;
      wr_pd   = wd;
      rd_prdy = rp;
   endtask

   // One clock cycle: sample at the falling edge, check against the model,
   // update the model, then advance to just after the rising edge.
   task automatic tick();
      logic expPrdy;
      @(negedge clk);
      sWe     = ram_we;
      sRe     = ram_re;
      sOre    = ram_ore;
      sPvld   = rd_pvld;
      sWrPrdy = wr_prdy;
      sPd     = rd_pd;
      expPrdy = prdyArmed && (expQ.size() < DEPTH);
      checkOutput("wr_prdy", WIDTH'(sWrPrdy), WIDTH'(expPrdy));
      checkOutput("ram_we", WIDTH'(sWe), WIDTH'(wr_pvld & expPrdy));
      sAcc = wr_pvld & expPrdy;
      if (sAcc) begin
         checkOutput("ram_wa", WIDTH'(ram_wa), WIDTH'(wrIdx % DEPTH));
         checkOutput("ram_di", ram_di, wr_pd);
      end
      if (expQ.size() == 0) checkOutput("rd_pvld_empty", WIDTH'(sPvld), WIDTH'(1'b0));
      if (prevStall) begin
         checkOutput("stall_pvld", WIDTH'(sPvld), WIDTH'(1'b1));
         checkOutput("stall_pd", sPd, prevPd);
      end
      if (sRe) begin
         checkOutput("ram_ra", WIDTH'(ram_ra), WIDTH'(issIdx % DEPTH));
         issIdx++;
      end
`ifdef SA_FIFO_RWSP_HWM_EN
      checkOutput("fifo_hwm", WIDTH'(fifo_hwm), WIDTH'(hwmModel));
`endif
      weCount += int'(sWe);
      sPop = sPvld & rd_prdy;
      if (sPop && expQ.size() > 0) begin
         checkOutput("rd_pd_order", sPd, expQ[0]);
         void'(expQ.pop_front());
         popCount++;
      end
      prevStall = sPvld & ~rd_prdy;
      prevPd    = sPd;
      if (sAcc) begin
         expQ.push_back(wr_pd);
         wrIdx++;
         accCount++;
      end
`ifdef SA_FIFO_RWSP_HWM_EN
      if (hwm_clr) hwmModel = 0;
      else if (expQ.size() > hwmModel) hwmModel = expQ.size();
`endif
      @(posedge clk);
      if (reset_) prdyArmed = 1'b1;
      #1;
   endtask

   // Hold reset for n cycles while the producer and consumer keep asking.
   task automatic applyReset(input int n);
      applyStimulus(1'b1, randWord(), 1'b1);
      reset_ = 1'b0;
      #1;
      checkOutput("rst_async_pvld", WIDTH'(rd_pvld), WIDTH'(1'b0));
      checkOutput("rst_async_we", WIDTH'(ram_we), WIDTH'(1'b0));
      repeat (n) begin
         @(negedge clk);
         checkOutput("rst_pvld", WIDTH'(rd_pvld), WIDTH'(1'b0));
         checkOutput("rst_re", WIDTH'(ram_re), WIDTH'(1'b0));
         checkOutput("rst_ore", WIDTH'(ram_ore), WIDTH'(1'b0));
         checkOutput("rst_we", WIDTH'(ram_we), WIDTH'(1'b0));
         checkOutput("rst_prdy", WIDTH'(wr_prdy), WIDTH'(1'b0));
         @(posedge clk);
         #1;
      end
      expQ.delete();
      prdyArmed = 1'b0;
      prevStall = 1'b0;
      wrIdx     = 0;
      issIdx    = 0;
`ifdef SA_FIFO_RWSP_HWM_EN
      hwmModel  = 0;
`endif
      reset_ = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
   endtask

   // A lone write into an empty FIFO must show up on rd_pd three cycles later.
   task automatic latencyProbe(input string tag, input logic [WIDTH-1:0] word);
      applyStimulus(1'b1, word, 1'b1);
      tick();
      checkOutput({tag, "_we"}, WIDTH'(sWe), WIDTH'(1'b1));
      applyStimulus(1'b0, '0, 1'b1);
      tick();
      checkOutput({tag, "_re1"}, WIDTH'({sRe, sOre, sPvld}), WIDTH'(3'b100));
      tick();
      checkOutput({tag, "_ore2"}, WIDTH'({sRe, sOre, sPvld}), WIDTH'(3'b010));
      tick();
      checkOutput({tag, "_pvld3"}, WIDTH'(sPvld), WIDTH'(1'b1));
      checkOutput({tag, "_pd3"}, sPd, word);
      tick();
      checkOutput({tag, "_pvld4"}, WIDTH'(sPvld), WIDTH'(1'b0));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] firstWord;
      int               start;
      int               popStart;
      int               written;
      int               cyc;
      logic [3:0]       rdPattern;

      applyStimulus(1'b0, '0, 1'b0);
      #2;
      $display("[TB] reset");
      applyReset(2);

      // Idle after reset: wr_prdy rises on the first edge.
      repeat (3) tick();

      $display("[TB] single write latency");
      latencyProbe("single", {1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF});

      $display("[TB] fill to full with consumer stalled");
      start = weCount;
      firstWord = randWord();
      applyStimulus(1'b1, firstWord, 1'b0);
      tick();
      repeat (11) begin
         applyStimulus(1'b1, randWord(), 1'b0);
         tick();
      end
      checkOutput("full_accepts", WIDTH'(weCount - start), WIDTH'(8));
      checkOutput("full_prdy", WIDTH'(sWrPrdy), WIDTH'(1'b0));
      checkOutput("full_head_pvld", WIDTH'(sPvld), WIDTH'(1'b1));
      checkOutput("full_head_pd", sPd, firstWord);

      $display("[TB] drain from full");
      applyStimulus(1'b0, '0, 1'b1);
      tick();
      checkOutput("drain_pop0", WIDTH'(sPop), WIDTH'(1'b1));
      for (int i = 1; i < 8; i++) begin
         tick();
         checkOutput("drain_pop", WIDTH'(sPop), WIDTH'(1'b1));
         if (i == 1) checkOutput("drain_prdy_back", WIDTH'(sWrPrdy), WIDTH'(1'b1));
      end
      tick();
      checkOutput("drain_empty", WIDTH'(sPvld), WIDTH'(1'b0));

      $display("[TB] streaming 20 words");
      rdPattern = 4'b1001;
      popStart = popCount;
      written  = 0;
      cyc      = 0;
      while ((popCount - popStart < 20) && (cyc < 600)) begin
         applyStimulus((written < 20) ? 1'($urandom_range(1, 0)) : 1'b0, randWord(),
                       rdPattern[cyc % 4]);
         tick();
         if (sAcc) written++;
         cyc++;
      end
      checkOutput("stream_popped", WIDTH'(popCount - popStart), WIDTH'(20));
      checkOutput("stream_written", WIDTH'(written), WIDTH'(20));

      $display("[TB] reset mid-stream");
      start = accCount;
      cyc   = 0;
      while ((accCount - start < 5) && (cyc < 20)) begin
         applyStimulus(1'b1, randWord(), 1'b0);
         tick();
         cyc++;
      end
      checkOutput("mid_fill5", WIDTH'(accCount - start), WIDTH'(5));
      applyReset(2);
      tick();
      latencyProbe("postrst", randWord());

`ifdef SA_FIFO_RWSP_HWM_EN
      $display("[TB] high watermark");
      repeat (6) begin
         applyStimulus(1'b1, randWord(), 1'b0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b1);
      repeat (12) tick();
      checkOutput("hwm_six", WIDTH'(fifo_hwm), WIDTH'(6));
      hwm_clr = 1'b1;
      applyStimulus(1'b1, randWord(), 1'b0);
      tick();
      hwm_clr = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      checkOutput("hwm_clr_wins", WIDTH'(fifo_hwm), WIDTH'(0));
      applyStimulus(1'b0, '0, 1'b1);
      repeat (5) tick();
      applyStimulus(1'b1, randWord(), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      checkOutput("hwm_one", WIDTH'(fifo_hwm), WIDTH'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
